// File: rtl/gf_reduce_seq_if.sv
// Handshake/data bundle for gf_reduce_seq.
// master: job producer / result consumer (drives in_*, out_ready).
// slave : the reduction stage (drives in_ready, out_valid, out, err_grade, busy).
//   in_valid/in_ready  job handshake
//   prod_in            2*DATA_WIDTH-bit carry-less product
//   polyn_red_in       reduction polynomial, bit i = coefficient of x^i
//   polyn_grade        field degree m
//   out_valid/out_ready result handshake
//   out, err_grade     reduced element and illegal-grade flag
//   busy               reduction in progress
interface gf_reduce_seq_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                          in_valid;
  logic                          in_ready;
  logic [2*DATA_WIDTH-1:0]       prod_in;
  logic [DATA_WIDTH:0]           polyn_red_in;
  logic [$clog2(DATA_WIDTH):0]   polyn_grade;
  logic                          out_valid;
  logic                          out_ready;
  logic [DATA_WIDTH-1:0]         out;
  logic                          err_grade;
  logic                          busy;

  modport master (
    output in_valid, prod_in, polyn_red_in, polyn_grade, out_ready,
    input  in_ready, out_valid, out, err_grade, busy
  );

  modport slave (
    input  in_valid, prod_in, polyn_red_in, polyn_grade, out_ready,
    output in_ready, out_valid, out, err_grade, busy
  );
endinterface

// File: rtl/gf_reduce_seq.sv
// Bit-serial GF(2^m) reduction stage.
// Takes a 2*DATA_WIDTH-bit carry-less product and a reduction polynomial
// of degree m, reduces the product modulo the polynomial one candidate bit
// per clock (from the top bit down to bit m), and returns the m-bit element
// over a valid/ready handshake. Illegal degrees (m < 2 or m > DATA_WIDTH)
// complete immediately with out=0 and err_grade=1.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    gf_reduce_seq_if slave modport (job in, result out, busy)
module gf_reduce_seq #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  gf_reduce_seq_if.slave  bus
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned GW = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned KW = $clog2(PW);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   r_q, r_d;
  logic [DW:0]     p_q, p_d;
  logic [GW-1:0]   m_q, m_d;
  logic [KW-1:0]   k_q, k_d;
  logic [DW-1:0]   out_q, out_d;
  logic            err_q, err_d;

  logic [DW-1:0]   low_mask;
  int unsigned     sh;
  logic            grade_legal;

  // Bits [m-1:0] of the result are meaningful; the rest are forced to zero.
  always_comb begin
    low_mask = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      low_mask[i] = (i < 32'(m_q));
    end
  end

  assign grade_legal = (32'(bus.polyn_grade) >= 32'd2) &&
                       (32'(bus.polyn_grade) <= DW);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    p_d     = p_q;
    m_d     = m_q;
    k_d     = k_q;
    out_d   = out_q;
    err_d   = err_q;
    sh      = 32'(k_q) - 32'(m_q);

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          r_d = bus.prod_in;
          m_d = bus.polyn_grade;
          // Keep coefficients below x^m, force the leading term, drop the rest.
          for (int unsigned i = 0; i <= DW; i++) begin
            if (i < 32'(bus.polyn_grade)) begin
              p_d[i] = bus.polyn_red_in[i];
            end else begin
              p_d[i] = (i == 32'(bus.polyn_grade));
            end
          end
          if (grade_legal) begin
            k_d     = KW'(PW - 1);
            state_d = RUN;
          end else begin
            out_d   = '0;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end

      RUN: begin
        if (r_q[k_q]) begin
          r_d = r_q ^ (PW'(p_q) << sh);
        end
        k_d = k_q - KW'(1);
        // The step at k == m is the last one; capture the already-updated
        // remainder so the result is registered on the same edge.
        if (32'(k_q) == 32'(m_q)) begin
          out_d   = r_d[DW-1:0] & low_mask;
          err_d   = 1'b0;
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      p_q     <= '0;
      m_q     <= '0;
      k_q     <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      p_q     <= p_d;
      m_q     <= m_d;
      k_q     <= k_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN);
  assign bus.out       = out_q;
  assign bus.err_grade = err_q;

endmodule

// File: tb/tb_gf_reduce_seq.sv
module tb_gf_reduce_seq;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 2 * DW;
  localparam int unsigned GW = $clog2(DW) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  gf_reduce_seq_if #(.DATA_WIDTH(DW)) bus ();

  gf_reduce_seq #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: sum of (x^i mod p) over set product bits, with x^i built by
  // repeated multiply-by-x and conditional subtraction of p.
  function automatic logic [DW-1:0] ref_mod(input logic [PW-1:0] prod,
                                            input logic [DW:0] poly,
                                            input int unsigned m);
    logic [DW:0] pf;
    logic [DW:0] xp;
    logic [DW:0] acc;
    pf = '0;
    for (int unsigned i = 0; i <= DW; i++) begin
      if (i < m) pf[i] = poly[i];
    end
    pf[m] = 1'b1;
    xp  = (DW+1)'(1);
    acc = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      if (prod[i]) acc = acc ^ xp;
      xp = xp << 1;
      if (xp[m]) xp = xp ^ pf;
    end
    return acc[DW-1:0];
  endfunction

  // Drives one job and waits for its result; all waits are bounded.
  task automatic run_job(input logic [PW-1:0] prod, input logic [DW:0] poly,
                         input logic [GW-1:0] grade, input int hold,
                         input bit flood,
                         output logic [DW-1:0] res, output logic err,
                         output int lat, output int busy_cnt,
                         output bit held_ok, output bit timeout);
    int w;
    timeout  = 1'b0;
    held_ok  = 1'b1;
    lat      = 0;
    busy_cnt = 0;
    res      = '0;
    err      = 1'b0;
    @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      timeout = 1'b1;
      return;
    end
    bus.in_valid     = 1'b1;
    bus.prod_in      = prod;
    bus.polyn_red_in = poly;
    bus.polyn_grade  = grade;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 200) begin
      if (bus.busy) busy_cnt++;
      lat++;
      @(negedge clk);
    end
    if (!bus.out_valid) begin
      timeout = 1'b1;
      return;
    end
    res = bus.out;
    err = bus.err_grade;
    for (int i = 0; i < hold; i++) begin
      if (flood) begin
        bus.in_valid     = 1'b1;
        bus.prod_in      = PW'($urandom);
        bus.polyn_red_in = (DW+1)'($urandom);
        bus.polyn_grade  = GW'(4);
      end
      @(posedge clk);
      @(negedge clk);
      if (bus.out !== res || bus.err_grade !== err || bus.out_valid !== 1'b1 ||
          bus.in_ready !== 1'b0)
        held_ok = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.out !== '0 || bus.err_grade !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b out=%h err=%b, required 1 0 0 00 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.out, bus.err_grade);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_aes();
    logic [DW-1:0] res; logic err; int lat, bc; bit hok, to;
    run_job(16'h3F7E, 9'h11B, GW'(8), 0, 1'b0, res, err, lat, bc, hok, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL aes_timeout: no result"); return; end
    n_checks++;
    if (res !== 8'h01 || err !== 1'b0) begin
      n_fail++; $display("FAIL aes_result: out=%h err=%b, required 01 0", res, err);
    end
    n_checks++;
    if (lat + 1 !== 9) begin
      n_fail++; $display("FAIL aes_latency: out_valid at edge %0d, required 9", lat + 1);
    end
    n_checks++;
    if (bc !== 8) begin
      n_fail++; $display("FAIL aes_busy: busy cycles %0d, required 8", bc);
    end
  endtask

  task automatic test_grade4();
    logic [DW-1:0] res; logic err; int lat, bc; bit hok, to;
    run_job(16'h0010, 9'h013, GW'(4), 0, 1'b0, res, err, lat, bc, hok, to);
    n_checks++;
    if (to || res !== 8'h03 || err !== 1'b0 || bc !== 12) begin
      n_fail++;
      $display("FAIL grade4_x4: out=%h err=%b busy=%0d to=%b, required 03 0 12 0", res, err, bc, to);
    end
    run_job(16'hFFFF, 9'h013, GW'(4), 0, 1'b0, res, err, lat, bc, hok, to);
    n_checks++;
    if (to || res !== ref_mod(16'hFFFF, 9'h013, 4) || bc !== 12) begin
      n_fail++;
      $display("FAIL grade4_ffff: out=%h busy=%0d, required %h 12", res, bc,
               ref_mod(16'hFFFF, 9'h013, 4));
    end
  endtask

  task automatic test_illegal();
    logic [DW-1:0] res; logic err; int lat, bc; bit hok, to;
    int grades[3] = '{1, 9, 0};
    foreach (grades[g]) begin
      run_job(PW'($urandom), 9'h11B, GW'(grades[g]), 0, 1'b0, res, err, lat, bc, hok, to);
      n_checks++;
      if (to || res !== '0 || err !== 1'b1) begin
        n_fail++;
        $display("FAIL illegal_result g=%0d: out=%h err=%b, required 00 1", grades[g], res, err);
      end
      n_checks++;
      if (lat + 1 !== 1 || bc !== 0) begin
        n_fail++;
        $display("FAIL illegal_timing g=%0d: valid edge %0d busy %0d, required 1 0",
                 grades[g], lat + 1, bc);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] res; logic err; int lat, bc; bit hok, to;
    run_job(16'h00A5, 9'h11B, GW'(8), 5, 1'b1, res, err, lat, bc, hok, to);
    n_checks++;
    if (to || res !== 8'hA5 || err !== 1'b0) begin
      n_fail++; $display("FAIL bp_result: out=%h err=%b, required a5 0", res, err);
    end
    n_checks++;
    if (!hok) begin
      n_fail++; $display("FAIL bp_hold: held=%b, required 1", hok);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: in_ready=%b out_valid=%b, required 1 0", bus.in_ready, bus.out_valid);
    end
    // in_valid was high in the handshake cycle; it must not have started a job.
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_no_accept: in_ready=%b busy=%b out_valid=%b, required 1 0 0",
               bus.in_ready, bus.busy, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] res; logic err; int lat, bc; bit hok, to;
    @(negedge clk);
    bus.in_valid     = 1'b1;
    bus.prod_in      = 16'h3F7E;
    bus.polyn_red_in = 9'h11B;
    bus.polyn_grade  = GW'(8);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
        bus.out !== '0 || bus.err_grade !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_state: in_ready=%b out_valid=%b busy=%b out=%h err=%b, required 1 0 0 00 0",
               bus.in_ready, bus.out_valid, bus.busy, bus.out, bus.err_grade);
    end
    run_job(16'h1234, 9'h11B, GW'(8), 0, 1'b0, res, err, lat, bc, hok, to);
    n_checks++;
    if (to || res !== ref_mod(16'h1234, 9'h11B, 8) || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_next: out=%h err=%b, required %h 0", res, err,
               ref_mod(16'h1234, 9'h11B, 8));
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] res, exp_res; logic err; int lat, bc; bit hok, to;
    logic [PW-1:0] prod; logic [DW:0] poly; int unsigned m;
    for (int j = 0; j < 200; j++) begin
      prod = PW'($urandom);
      poly = (DW+1)'($urandom);
      m    = $urandom_range(2, DW);
      exp_res = ref_mod(prod, poly, m);
      run_job(prod, poly, GW'(m), int'($urandom_range(0, 3)), 1'b0,
              res, err, lat, bc, hok, to);
      n_checks++;
      if (to || res !== exp_res || err !== 1'b0 || lat !== int'(PW - m) || !hok) begin
        n_fail++;
        $display("FAIL b2b job %0d: prod=%h poly=%h m=%0d out=%h err=%b lat=%0d held=%b, required %h 0 %0d 1",
                 j, prod, poly, m, res, err, lat, hok, exp_res, PW - m);
      end
      n_checks++;
      if (bus.out_valid !== 1'b0) begin
        n_fail++; $display("FAIL b2b_dup job %0d: out_valid=%b after handshake, required 0", j, bus.out_valid);
      end
    end
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.prod_in      = '0;
    bus.polyn_red_in = '0;
    bus.polyn_grade  = '0;
    bus.out_ready    = 1'b0;
    test_reset();
    test_aes();
    test_grade4();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
